spike_packet_encoder: RTL and testbench

Neuron-side packet source feeding the network interface's injection path. Accepts spike events (neuron id plus destination route) from the neuron core, buffers them in a small FIFO, stamps each with the current time step, and serialises each event into a two-flit spike packet (head + tail) in the 38-bit flit format. The network interface consumes the flits over a valid/ready handshake. This is the mirror of the packet decoder on the receive side.

---
 rtl/noc_pkg.sv | 54 +++++
 rtl/spike_packet_encoder_if.sv | 23 ++
 rtl/spike_packet_encoder_fifo.sv | 55 +++++
 rtl/spike_packet_encoder.sv | 113 +++++++++++
 tb/tb_spike_packet_encoder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, type/class codes, encoder FSM states
// and helpers that assemble spike head/tail flits.
package noc_pkg;

  localparam int FLIT_W = 38;

  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b01;

  localparam logic [2:0] CLASS_SPIKE = 3'b000;

  localparam int TYPE_LSB  = 36;
  localparam int VC_LSB    = 32;
  localparam int VC_W      = 4;
  localparam int CLASS_LSB = 29;
  localparam int CLASS_W   = 3;
  localparam int ROUTE_W   = 29;
  localparam int NID_LSB   = 16;
  localparam int NID_W     = 8;
  localparam int DATA_LSB  = 0;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_TAIL
  } enc_state_t;

  function automatic logic [FLIT_W-1:0] make_head(input logic [VC_W-1:0] vc,
                                                   input logic [ROUTE_W-1:0] route);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[TYPE_LSB +: 2]        = FT_HEAD;
    f[VC_LSB +: VC_W]       = vc;
    f[CLASS_LSB +: CLASS_W] = CLASS_SPIKE;
    f[0 +: ROUTE_W]         = route;
    return f;
  endfunction

  // Bits [31:24] of the tail stay zero: reserved plus spike sub-class.
  function automatic logic [FLIT_W-1:0] make_tail(input logic [VC_W-1:0] vc,
                                                   input logic [NID_W-1:0] nid,
                                                   input logic [DATA_W-1:0] data);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[TYPE_LSB +: 2]      = FT_TAIL;
    f[VC_LSB +: VC_W]     = vc;
    f[NID_LSB +: NID_W]   = nid;
    f[DATA_LSB +: DATA_W] = data;
    return f;
  endfunction

endpackage

// File: rtl/spike_packet_encoder_if.sv
// Spike event input and flit output handshakes of the spike packet encoder.
// The encoder uses the master modport; the neuron core / NI side uses slave.
interface spike_packet_encoder_if;
  import noc_pkg::*;

  logic                spike_valid;
  logic                spike_ready;
  logic [NID_W-1:0]    spike_neuron_id;
  logic [ROUTE_W-1:0]  spike_route;
  logic [FLIT_W-1:0]   flit_out;
  logic                flit_out_valid;
  logic                flit_out_ready;

  modport master (
    input  spike_valid, spike_neuron_id, spike_route, flit_out_ready,
    output spike_ready, flit_out, flit_out_valid
  );

  modport slave (
    output spike_valid, spike_neuron_id, spike_route, flit_out_ready,
    input  spike_ready, flit_out, flit_out_valid
  );
endinterface

// File: rtl/spike_packet_encoder_fifo.sv
// Synchronous FIFO with occupancy count; exposes the oldest entry and the one
// behind it so a consumer can chain packets without a bubble.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_next   = rd_ptr + AW'(1);
  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/spike_packet_encoder.sv
// Buffers timestamped spike events and serialises each into a head+tail
// packet on a registered valid/ready flit stream.
module spike_packet_encoder
  import noc_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] VC_ID      = 4'b0001,
  parameter int         TS_WIDTH   = 16
) (
  input  logic                          neuron_clk,
  input  logic                          neuron_rst_n,
  input  logic                          start,
  input  logic                          step,
  spike_packet_encoder_if.master        bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [NID_W-1:0]    id;
    logic [ROUTE_W-1:0]  route;
    logic [TS_WIDTH-1:0] ts;
  } event_t;

  enc_state_t          state, state_n;
  logic [FLIT_W-1:0]   flit_q, flit_n;
  logic                valid_q, valid_n;
  logic [TS_WIDTH-1:0] ts;
  logic                push, pop, full, empty;
  event_t              wr_ev, head_ev, next_ev;

  assign wr_ev            = '{id: bus.spike_neuron_id, route: bus.spike_route, ts: ts};
  assign push             = bus.spike_valid && !full;
  assign bus.spike_ready  = !full;
  assign bus.flit_out     = flit_q;
  assign bus.flit_out_valid = valid_q;

  sync_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (neuron_clk),
    .rst_n     (neuron_rst_n),
    .push      (push),
    .pop       (pop),
    .wdata     (wr_ev),
    .head_data (head_ev),
    .next_data (next_ev),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  // A push in the same cycle as a step captures the pre-increment time.
  always_ff @(posedge neuron_clk or negedge neuron_rst_n) begin
    if (!neuron_rst_n) ts <= '0;
    else if (step)     ts <= ts + TS_WIDTH'(1);
  end

  always_ff @(posedge neuron_clk or negedge neuron_rst_n) begin
    if (!neuron_rst_n) begin
      state   <= ST_IDLE;
      flit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      flit_q  <= flit_n;
      valid_q <= valid_n;
    end
  end

  // The head entry stays in the FIFO until its tail is accepted, so the
  // follow-on packet is built from the entry behind it.
  always_comb begin
    state_n = state;
    flit_n  = flit_q;
    valid_n = valid_q;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && start) begin
          state_n = ST_HEAD;
          flit_n  = make_head(VC_ID, head_ev.route);
          valid_n = 1'b1;
        end
      end
      ST_HEAD: begin
        if (bus.flit_out_ready) begin
          state_n = ST_TAIL;
          flit_n  = make_tail(VC_ID, head_ev.id, head_ev.ts);
        end
      end
      ST_TAIL: begin
        if (bus.flit_out_ready) begin
          pop = 1'b1;
          if (start && (fifo_count > CW'(1))) begin
            state_n = ST_HEAD;
            flit_n  = make_head(VC_ID, next_ev.route);
          end else begin
            state_n = ST_IDLE;
            flit_n  = '0;
            valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        flit_n  = '0;
        valid_n = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_spike_packet_encoder.sv
// Directed plus randomized bench for spike_packet_encoder, checked against a
// queue-based event model built from the packet format rules.
module tb_spike_packet_encoder;

  localparam logic [3:0] VC = 4'b0001;

  typedef struct {
    logic [7:0]  id;
    logic [28:0] route;
    logic [15:0] ts;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        step;
  logic [3:0]  fifo_count;

  spike_packet_encoder_if bus();

  spike_packet_encoder #(
    .FIFO_DEPTH (8),
    .VC_ID      (4'b0001),
    .TS_WIDTH   (16)
  ) dut (
    .neuron_clk   (clk),
    .neuron_rst_n (rst_n),
    .start        (start),
    .step         (step),
    .bus          (bus),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  ev_t         ev_q[$];
  bit          half_sent = 0;
  logic [15:0] ts_m = '0;

  function automatic logic [37:0] model_head(input logic [28:0] route);
    return {2'b10, VC, 3'b000, route};
  endfunction

  function automatic logic [37:0] model_tail(input logic [7:0] id, input logic [15:0] ts);
    return {2'b01, VC, 8'h00, id, ts};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic sv, input logic [7:0] id, input logic [28:0] route,
                                input logic stp, input logic strt, input logic rdy);
    bus.spike_valid     = sv;
    bus.spike_neuron_id = id;
    bus.spike_route     = route;
    step                = stp;
    start               = strt;
    bus.flit_out_ready  = rdy;
  endtask

  task automatic model_clear();
    ev_q.delete();
    half_sent = 0;
    ts_m = '0;
  endtask

  // One clock: snapshot pre-edge inputs/outputs, advance, then check and update the model.
  task automatic clock_cycle();
    logic        p_rst, p_valid, p_rdy, p_start, p_step, p_sv, p_sready;
    logic [37:0] p_flit, exp_flit;
    logic [7:0]  p_id;
    logic [28:0] p_route;
    int          n_before;
    ev_t         e;
    p_rst    = rst_n;
    p_valid  = bus.flit_out_valid;
    p_rdy    = bus.flit_out_ready;
    p_flit   = bus.flit_out;
    p_start  = start;
    p_step   = step;
    p_sv     = bus.spike_valid;
    p_sready = bus.spike_ready;
    p_id     = bus.spike_neuron_id;
    p_route  = bus.spike_route;
    n_before = ev_q.size();
    @(posedge clk);
    #1;
    if (!p_rst) begin
      check_output("in_reset_valid", bus.flit_out_valid, 1'b0);
      check_output("in_reset_count", fifo_count, 4'd0);
      return;
    end
    check_output("spike_ready_pre", p_sready, n_before < 8);
    if (p_valid && p_rdy) begin
      if (n_before == 0) begin
        check_output("flit_unexpected", p_valid, 1'b0);
      end else begin
        e = ev_q[0];
        if (half_sent) begin
          exp_flit = model_tail(e.id, e.ts);
          check_output("flit_tail", p_flit, exp_flit);
          void'(ev_q.pop_front());
          half_sent = 0;
          check_output("valid_after_tail", bus.flit_out_valid, p_start && (n_before > 1));
        end else begin
          exp_flit = model_head(e.route);
          check_output("flit_head", p_flit, exp_flit);
          half_sent = 1;
          check_output("tail_follows_head", bus.flit_out_valid, 1'b1);
        end
      end
    end else if (p_valid) begin
      check_output("hold_flit", bus.flit_out, p_flit);
      check_output("hold_valid", bus.flit_out_valid, 1'b1);
    end else begin
      check_output("head_issue", bus.flit_out_valid, p_start && (n_before > 0));
    end
    if (p_sv && (n_before < 8)) ev_q.push_back('{id: p_id, route: p_route, ts: ts_m});
    if (p_step) ts_m = ts_m + 16'd1;
    check_output("fifo_count", fifo_count, ev_q.size());
  endtask

  task automatic drain();
    int n = 0;
    apply_stimulus(1'b0, 8'h00, 29'h0, 1'b0, 1'b1, 1'b1);
    while ((ev_q.size() != 0 || bus.flit_out_valid) && n < 200) begin
      clock_cycle();
      n++;
    end
    check_output("drain_timeout", ev_q.size(), 0);
  endtask

  initial begin
    logic [37:0] head_lit, tail_lit, held;
    logic [28:0] r;
    int          nvalid;

    head_lit = {2'b10, 4'b0001, 3'b000, 29'h0104_1041};
    tail_lit = {2'b01, 4'b0001, 4'b0000, 4'b0000, 8'h03, 16'h0005};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 8'h00, 29'h0, 1'b0, 1'b0, 1'b1);
    model_clear();
    #2;
    check_output("rst_flit", bus.flit_out, 38'h0);
    check_output("rst_valid", bus.flit_out_valid, 1'b0);
    check_output("rst_spike_ready", bus.spike_ready, 1'b1);
    check_output("rst_count", fifo_count, 4'd0);
    clock_cycle();
    clock_cycle();
    rst_n = 1'b1;

    $display("[TB] single spike");
    apply_stimulus(1'b0, 8'h00, 29'h0, 1'b1, 1'b1, 1'b1);
    repeat (5) clock_cycle();
    apply_stimulus(1'b1, 8'h03, 29'h0104_1041, 1'b0, 1'b1, 1'b1);
    clock_cycle();
    bus.spike_valid = 1'b0;
    clock_cycle();
    check_output("single_head", bus.flit_out, head_lit);
    clock_cycle();
    check_output("single_tail", bus.flit_out, tail_lit);
    clock_cycle();
    check_output("single_idle", bus.flit_out_valid, 1'b0);

    $display("[TB] back-pressure");
    r = 29'($urandom);
    apply_stimulus(1'b1, 8'($urandom), r, 1'b0, 1'b1, 1'b0);
    clock_cycle();
    bus.spike_valid = 1'b0;
    clock_cycle();
    held = bus.flit_out;
    repeat (3) clock_cycle();
    check_output("bp_head_held", bus.flit_out, held);
    check_output("bp_head_value", bus.flit_out, model_head(r));
    bus.flit_out_ready = 1'b1;
    clock_cycle();
    bus.flit_out_ready = 1'b0;
    held = bus.flit_out;
    repeat (3) clock_cycle();
    check_output("bp_tail_held", bus.flit_out, held);
    bus.flit_out_ready = 1'b1;
    clock_cycle();
    check_output("bp_done_valid", bus.flit_out_valid, 1'b0);
    check_output("bp_done_count", fifo_count, 4'd0);

    $display("[TB] full fifo");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 8'($urandom), 29'($urandom), 1'b0, 1'b0, 1'b1);
      clock_cycle();
    end
    check_output("full_count", fifo_count, 4'd8);
    check_output("full_spike_ready", bus.spike_ready, 1'b0);
    apply_stimulus(1'b0, 8'h00, 29'h0, 1'b0, 1'b1, 1'b1);
    nvalid = 0;
    repeat (17) begin
      clock_cycle();
      if (bus.flit_out_valid) nvalid++;
    end
    check_output("full_back_to_back", nvalid, 16);
    check_output("full_drained", fifo_count, 4'd0);

    $display("[TB] timestamp wrap");
    apply_stimulus(1'b0, 8'h00, 29'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 70000 && ts_m != 16'hFFFF; i++) clock_cycle();
    check_output("wrap_preload", ts_m, 16'hFFFF);
    apply_stimulus(1'b1, 8'hA5, 29'($urandom), 1'b1, 1'b1, 1'b1);
    clock_cycle();
    apply_stimulus(1'b1, 8'h5A, 29'($urandom), 1'b0, 1'b1, 1'b1);
    clock_cycle();
    bus.spike_valid = 1'b0;
    clock_cycle();
    check_output("wrap_ts_ffff", bus.flit_out[15:0], 16'hFFFF);
    clock_cycle();
    clock_cycle();
    check_output("wrap_ts_0000", bus.flit_out[15:0], 16'h0000);
    drain();

    $display("[TB] start dropped mid-packet");
    apply_stimulus(1'b1, 8'($urandom), 29'($urandom), 1'b0, 1'b1, 1'b0);
    clock_cycle();
    bus.spike_valid = 1'b0;
    clock_cycle();
    start = 1'b0;
    clock_cycle();
    bus.flit_out_ready = 1'b1;
    clock_cycle();
    check_output("nostart_tail_type", bus.flit_out[37:36], 2'b01);
    clock_cycle();
    apply_stimulus(1'b1, 8'($urandom), 29'($urandom), 1'b0, 1'b0, 1'b1);
    clock_cycle();
    bus.spike_valid = 1'b0;
    repeat (4) clock_cycle();
    check_output("nostart_no_head", bus.flit_out_valid, 1'b0);
    check_output("nostart_buffered", fifo_count, 4'd1);
    start = 1'b1;
    clock_cycle();
    check_output("restart_head_type", bus.flit_out[37:36], 2'b10);
    drain();

    $display("[TB] reset mid-packet");
    apply_stimulus(1'b1, 8'($urandom), 29'($urandom), 1'b0, 1'b1, 1'b1);
    clock_cycle();
    bus.spike_valid = 1'b0;
    clock_cycle();
    apply_stimulus(1'b1, 8'($urandom), 29'($urandom), 1'b0, 1'b1, 1'b1);
    clock_cycle();
    apply_stimulus(1'b0, 8'h00, 29'h0, 1'b0, 1'b1, 1'b0);
    clock_cycle();
    check_output("pre_reset_tail_type", bus.flit_out[37:36], 2'b01);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_flit", bus.flit_out, 38'h0);
    check_output("async_rst_valid", bus.flit_out_valid, 1'b0);
    check_output("async_rst_spike_ready", bus.spike_ready, 1'b1);
    check_output("async_rst_count", fifo_count, 4'd0);
    model_clear();
    clock_cycle();
    rst_n = 1'b1;
    r = 29'($urandom);
    apply_stimulus(1'b1, 8'h77, r, 1'b0, 1'b1, 1'b1);
    clock_cycle();
    bus.spike_valid = 1'b0;
    clock_cycle();
    check_output("post_reset_head", bus.flit_out, model_head(r));
    clock_cycle();
    check_output("post_reset_tail", bus.flit_out, model_tail(8'h77, 16'h0000));
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), 29'($urandom),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 3) != 0));
      clock_cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
